// File: rtl/fighter_pkg.sv
// fighter_pkg: pose states and tuning constants shared by fighter logic.
// P2_BLOCK_CHIP_EN selects chip damage on blocked hits (2) instead of full absorption (0).
package fighter_pkg;
    typedef enum logic [3:0] {IDLE, MOVE, CROUCH, JUMP, KICK, PUNCH, CPUNCH, BLOCK, DEAD} pose_t;
    localparam logic [9:0] GROUND_Y      = 10'd300;
    localparam logic [9:0] X_MIN         = 10'd0;
    localparam logic [9:0] X_MAX         = 10'd512;
    localparam logic [9:0] X_START       = 10'd64;
    localparam logic [9:0] MOVE_STEP     = 10'd2;
    localparam logic [9:0] JUMP_STEP     = 10'd4;
    localparam int         JUMP_FRAMES   = 32;
    localparam int         ATTACK_FRAMES = 8;
    localparam logic [4:0] JUMP_LAST     = 5'(JUMP_FRAMES - 1);
    localparam logic [4:0] JUMP_HALF     = 5'(JUMP_FRAMES / 2);
    localparam logic [2:0] ATTACK_LAST   = 3'(ATTACK_FRAMES - 1);
    localparam logic [6:0] HIT_DAMAGE    = 7'd10;
    localparam logic [6:0] MAX_HEALTH    = 7'd100;
`ifdef P2_BLOCK_CHIP_EN
    localparam logic [6:0] BLOCK_CHIP    = 7'd2;
`else
    localparam logic [6:0] BLOCK_CHIP    = 7'd0;
`endif

    function automatic logic is_attack(pose_t s);
        return s inside {KICK, PUNCH, CPUNCH};
    endfunction
endpackage

// File: rtl/fighter_health.sv
// fighter_health: health register with saturating hit damage, reduced while blocking.
module fighter_health
    import fighter_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       hit_in,
    input  logic       blocking,
    input  logic       dead,
    output logic [6:0] health
);
    logic [6:0] dmg;

    always_comb dmg = blocking ? BLOCK_CHIP : HIT_DAMAGE;

    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset)
            health <= MAX_HEALTH;
        else if (hit_in && !dead)
            health <= (health > dmg) ? health - dmg : 7'd0;
endmodule

// File: rtl/player2_controller.sv
// player2_controller: player-2 pose FSM, sprite position and health for the fighting game.
// Blocked-hit damage depends on P2_BLOCK_CHIP_EN (see fighter_pkg).
module player2_controller
    import fighter_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_punch,
    input  logic       key_kick,
    input  logic       key_block,
    input  logic [9:0] opp_x,
    input  logic       hit_in,
    output logic [9:0] spritex,
    output logic [9:0] spritey,
    output logic       stand,
    output logic       crouch,
    output logic       jump,
    output logic       kick,
    output logic       punch,
    output logic       crouchpunch,
    output logic       move,
    output logic       block,
    output logic       dead,
    output logic       flip,
    output logic [6:0] health
);
    pose_t      state, next_state, base_state;
    logic [2:0] atk_cnt;
    logic [4:0] jmp_cnt;
    logic [9:0] x_next;
    logic [8:0] flags_d;

    fighter_health u_health (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .hit_in    (hit_in),
        .blocking  (state == BLOCK),
        .dead      (state == DEAD),
        .health    (health)
    );

    // Counters wrap to 0 on their last frame, so a chained re-entry starts fresh.
    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) begin
            state   <= IDLE;
            atk_cnt <= 3'd0;
            jmp_cnt <= 5'd0;
        end else begin
            state   <= next_state;
            atk_cnt <= (is_attack(state) && is_attack(next_state)) ? atk_cnt + 3'd1 : 3'd0;
            jmp_cnt <= (state == JUMP && next_state == JUMP) ? jmp_cnt + 5'd1 : 5'd0;
        end

    always_comb begin
        base_state = (health == 7'd0)          ? DEAD   :
                     key_block                 ? BLOCK  :
                     key_kick                  ? KICK   :
                     (key_punch && key_down)   ? CPUNCH :
                     key_punch                 ? PUNCH  :
                     key_up                    ? JUMP   :
                     key_down                  ? CROUCH :
                     (key_left ^ key_right)    ? MOVE   : IDLE;
        next_state = (state == DEAD || health == 7'd0)               ? DEAD  :
                     (is_attack(state) && atk_cnt != ATTACK_LAST)    ? state :
                     (state == JUMP && jmp_cnt != JUMP_LAST)         ? JUMP  : base_state;
    end

    always_comb begin
        x_next  = !(next_state inside {MOVE, JUMP}) ? spritex :
                  (key_right && !key_left) ? ((spritex >= X_MAX - MOVE_STEP) ? X_MAX : spritex + MOVE_STEP) :
                  (key_left && !key_right) ? ((spritex <= X_MIN + MOVE_STEP) ? X_MIN : spritex - MOVE_STEP) : spritex;
        flags_d = {next_state inside {IDLE, MOVE}, next_state == CROUCH, next_state == JUMP, next_state == KICK,
                   next_state == PUNCH, next_state == CPUNCH, next_state == MOVE, next_state == BLOCK, next_state == DEAD};
    end

    // Off-jump frames always sit on the ground, which also snaps a jump aborted by death.
    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) begin
            {stand, crouch, jump, kick, punch, crouchpunch, move, block, dead} <= 9'b1_0000_0000;
            flip    <= 1'b1;
            spritex <= X_START;
            spritey <= GROUND_Y;
        end else begin
            {stand, crouch, jump, kick, punch, crouchpunch, move, block, dead} <= flags_d;
            spritex <= x_next;
            spritey <= (state == JUMP && next_state != DEAD) ?
                       ((jmp_cnt < JUMP_HALF) ? spritey - JUMP_STEP : spritey + JUMP_STEP) : GROUND_Y;
            if (!(next_state inside {JUMP, KICK, PUNCH, CPUNCH}))
                flip <= opp_x < x_next;
        end
endmodule

// File: tb/tb_player2_controller.sv
// tb_player2_controller: directed scenarios plus randomized run against a frame-level reference model.
module tb_player2_controller;
    logic       frame_clk = 1'b0;
    logic       Reset = 1'b0;
    logic       key_left, key_right, key_up, key_down, key_punch, key_kick, key_block, hit_in;
    logic [9:0] opp_x;
    logic [9:0] spritex, spritey;
    logic       stand, crouch, jump, kick, punch, crouchpunch, move, block, dead, flip;
    logic [6:0] health;
    int errors = 0;
    int checks = 0;

`ifdef P2_BLOCK_CHIP_EN
    localparam int CHIP = 2;
`else
    localparam int CHIP = 0;
`endif
    localparam int M_IDLE = 0, M_MOVE = 1, M_CROUCH = 2, M_JUMP = 3, M_KICK = 4,
                   M_PUNCH = 5, M_CPUNCH = 6, M_BLOCK = 7, M_DEAD = 8;

    int m_mode, m_el, m_x, m_y, m_h;
    bit m_flip;

    player2_controller dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
        .key_punch(key_punch), .key_kick(key_kick), .key_block(key_block),
        .opp_x(opp_x), .hit_in(hit_in),
        .spritex(spritex), .spritey(spritey),
        .stand(stand), .crouch(crouch), .jump(jump), .kick(kick), .punch(punch),
        .crouchpunch(crouchpunch), .move(move), .block(block), .dead(dead), .flip(flip),
        .health(health)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [9:0] dut_pose();
        return {stand, crouch, jump, kick, punch, crouchpunch, move, block, dead, flip};
    endfunction

    function automatic int choose();
        if (key_block) return M_BLOCK;
        if (key_kick) return M_KICK;
        if (key_punch && key_down) return M_CPUNCH;
        if (key_punch) return M_PUNCH;
        if (key_up) return M_JUMP;
        if (key_down) return M_CROUCH;
        if (key_left != key_right) return M_MOVE;
        return M_IDLE;
    endfunction

    function automatic logic [8:0] model_flags();
        return {m_mode == M_IDLE || m_mode == M_MOVE, m_mode == M_CROUCH, m_mode == M_JUMP,
                m_mode == M_KICK, m_mode == M_PUNCH, m_mode == M_CPUNCH, m_mode == M_MOVE,
                m_mode == M_BLOCK, m_mode == M_DEAD};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_el = 0; m_x = 64; m_y = 300; m_h = 100; m_flip = 1'b1;
    endtask

    // One frame of the game rules, applied to the inputs seen at this edge.
    task automatic model_step();
        int prev = m_mode;
        int ph = m_h;
        int len = (prev == M_JUMP) ? 32 : 8;
        bit action = prev inside {M_JUMP, M_KICK, M_PUNCH, M_CPUNCH};
        bit stay = action && (m_el < len - 1);
        int nm, dmg, up;
        if (hit_in && prev != M_DEAD) begin
            dmg = (prev == M_BLOCK) ? CHIP : 10;
            m_h = (ph > dmg) ? ph - dmg : 0;
        end
        nm = (prev == M_DEAD || ph == 0) ? M_DEAD : stay ? prev : choose();
        up = (m_el + 1 <= 16) ? m_el + 1 : 32 - (m_el + 1);
        m_y = (prev == M_JUMP && nm != M_DEAD) ? 300 - 4 * up : 300;
        m_el = (stay && nm == prev) ? m_el + 1 : 0;
        if (nm == M_MOVE || nm == M_JUMP) begin
            if (key_right && !key_left) m_x = (m_x + 2 > 512) ? 512 : m_x + 2;
            if (key_left && !key_right) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
        end
        if (!(nm inside {M_JUMP, M_KICK, M_PUNCH, M_CPUNCH})) m_flip = (int'(opp_x) < m_x);
        m_mode = nm;
    endtask

    task automatic cycle();
        @(posedge frame_clk);
        model_step();
        #1;
    endtask

    task automatic clear_keys();
        {key_left, key_right, key_up, key_down, key_punch, key_kick, key_block, hit_in} = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        #2;
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_keys(); opp_x = 10'd0; do_reset();
        checks++; if (spritex !== 10'd64) begin errors++; $display("FAIL reset_x: got %0d expected 64", spritex); end
        checks++; if (spritey !== 10'd300) begin errors++; $display("FAIL reset_y: got %0d expected 300", spritey); end
        checks++; if (health !== 7'd100) begin errors++; $display("FAIL reset_health: got %0d expected 100", health); end
        checks++; if (dut_pose() !== 10'b1000000001) begin errors++; $display("FAIL reset_pose: got %b expected 1000000001", dut_pose()); end
    endtask

    task automatic test_move();
        clear_keys(); opp_x = 10'd0; do_reset();
        key_right = 1'b1;
        repeat (10) cycle();
        checks++; if (spritex !== 10'd84) begin errors++; $display("FAIL move_x: got %0d expected 84", spritex); end
        checks++; if (dut_pose() !== 10'b1000001001) begin errors++; $display("FAIL move_pose: got %b expected 1000001001", dut_pose()); end
    endtask

    task automatic test_jump();
        int n = 0, miny = 1023, y16 = -1;
        clear_keys(); opp_x = 10'd0; do_reset();
        key_up = 1'b1;
        cycle();
        key_up = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (jump) begin
                if (n == 16) y16 = int'(spritey);
                if (int'(spritey) < miny) miny = int'(spritey);
                n++;
            end
            cycle();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL jump_len: got %0d expected 32", n); end
        checks++; if (miny != 236) begin errors++; $display("FAIL jump_min: got %0d expected 236", miny); end
        checks++; if (y16 != 236) begin errors++; $display("FAIL jump_f16: got %0d expected 236", y16); end
        checks++; if (spritey !== 10'd300) begin errors++; $display("FAIL jump_land: got %0d expected 300", spritey); end
        checks++; if (dut_pose() !== 10'b1000000001) begin errors++; $display("FAIL jump_after: got %b expected 1000000001", dut_pose()); end
    endtask

    task automatic test_cpunch();
        clear_keys(); opp_x = 10'd0; do_reset();
        key_down = 1'b1; key_punch = 1'b1;
        cycle();
        checks++; if (dut_pose() !== 10'b0000010001) begin errors++; $display("FAIL cpunch_start: got %b expected 0000010001", dut_pose()); end
        for (int i = 0; i < 7; i++) begin
            {key_left, key_right, key_up, key_down, key_punch, key_kick, key_block} = 7'($urandom);
            cycle();
            checks++; if (dut_pose() !== 10'b0000010001) begin errors++; $display("FAIL cpunch_hold%0d: got %b expected 0000010001", i, dut_pose()); end
        end
        clear_keys();
        cycle();
        checks++; if (dut_pose() !== 10'b1000000001) begin errors++; $display("FAIL cpunch_end: got %b expected 1000000001", dut_pose()); end
        checks++; if (spritex !== 10'd64) begin errors++; $display("FAIL cpunch_x: got %0d expected 64", spritex); end
    endtask

    task automatic test_death();
        clear_keys(); opp_x = 10'd0; do_reset();
        for (int i = 0; i < 10; i++) begin
            hit_in = 1'b1;
            cycle();
            hit_in = 1'b0;
            checks++; if (health !== 7'(100 - 10 * (i + 1))) begin errors++; $display("FAIL hit%0d: got %0d expected %0d", i, health, 100 - 10 * (i + 1)); end
            if (i < 9) cycle();
        end
        checks++; if (dead !== 1'b0) begin errors++; $display("FAIL dead_early: got %b expected 0", dead); end
        cycle();
        checks++; if (dut_pose() !== 10'b0000000011) begin errors++; $display("FAIL dead_pose: got %b expected 0000000011", dut_pose()); end
        for (int i = 0; i < 5; i++) begin
            {key_left, key_right, key_up, key_down, key_punch, key_kick, key_block, hit_in} = 8'($urandom);
            cycle();
            checks++; if (dead !== 1'b1 || spritex !== 10'd64 || health !== 7'd0) begin errors++; $display("FAIL dead_hold%0d: got dead=%b x=%0d h=%0d expected 1 64 0", i, dead, spritex, health); end
        end
    endtask

    task automatic test_block();
        clear_keys(); opp_x = 10'd0; do_reset();
        key_block = 1'b1;
        cycle();
        repeat (3) begin
            hit_in = 1'b1; cycle(); hit_in = 1'b0; cycle();
        end
        checks++; if (health !== 7'(100 - 3 * CHIP)) begin errors++; $display("FAIL block_health: got %0d expected %0d", health, 100 - 3 * CHIP); end
        checks++; if (block !== 1'b1) begin errors++; $display("FAIL block_pose: got %b expected 1", block); end
    endtask

    task automatic test_clamp_reset();
        clear_keys(); opp_x = 10'd0; do_reset();
        key_right = 1'b1;
        repeat (223) cycle();
        checks++; if (spritex !== 10'd510) begin errors++; $display("FAIL clamp_510: got %0d expected 510", spritex); end
        repeat (5) cycle();
        checks++; if (spritex !== 10'd512) begin errors++; $display("FAIL clamp_512: got %0d expected 512", spritex); end
        clear_keys(); key_kick = 1'b1;
        cycle();
        key_kick = 1'b0;
        repeat (3) cycle();
        checks++; if (kick !== 1'b1) begin errors++; $display("FAIL kick_mid: got %b expected 1", kick); end
        do_reset();
        checks++; if (spritex !== 10'd64 || spritey !== 10'd300 || health !== 7'd100) begin errors++; $display("FAIL kick_reset_pos: got x=%0d y=%0d h=%0d expected 64 300 100", spritex, spritey, health); end
        checks++; if (dut_pose() !== 10'b1000000001) begin errors++; $display("FAIL kick_reset_pose: got %b expected 1000000001", dut_pose()); end
        cycle();
        checks++; if (dut_pose() !== 10'b1000000001 || spritex !== 10'd64) begin errors++; $display("FAIL kick_after: got %b x=%0d expected 1000000001 64", dut_pose(), spritex); end
    endtask

    task automatic test_random();
        logic [36:0] got, exp;
        clear_keys(); do_reset();
        for (int i = 0; i < 3000; i++) begin
            key_left  = ($urandom_range(0, 2) == 0);
            key_right = ($urandom_range(0, 2) == 0);
            key_up    = ($urandom_range(0, 9) == 0);
            key_down  = ($urandom_range(0, 7) == 0);
            key_punch = ($urandom_range(0, 9) == 0);
            key_kick  = ($urandom_range(0, 11) == 0);
            key_block = ($urandom_range(0, 9) == 0);
            hit_in    = ($urandom_range(0, 99) < 2);
            opp_x     = 10'($urandom_range(0, 640));
            cycle();
            if ($urandom_range(0, 299) == 0) do_reset();
            got = {spritex, spritey, health, dut_pose()};
            exp = {10'(m_x), 10'(m_y), 7'(m_h), model_flags(), m_flip};
            checks++; if (got !== exp) begin errors++; $display("FAIL rand%0d: got %h expected %h", i, got, exp); end
        end
    endtask

    initial begin
        clear_keys();
        opp_x = 10'd0;
        #1;
        test_reset();
        test_move();
        test_jump();
        test_cpunch();
        test_death();
        test_block();
        test_clamp_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
